// File: rtl/h14tx_pattern_gen.sv
// h14tx_pattern_gen -- video test-pattern source for the h14tx_dvo raster.
//
// Takes the raster coordinates produced by h14tx_dvo and returns one registered
// 24-bit RGB pixel per clock (latency 1). A debounced push-switch steps through
// five patterns; a mode change is deferred to the frame boundary so a frame is
// never split between two patterns.
//
// Ports:
//   clk        pixel clock
//   rst        synchronous active-high reset
//   switch     raw asynchronous push-switch
//   x          pixel column, 0..HTotal-1
//   y          line number, 0..VTotal-1
//   video      {R,G,B} = {[23:16],[15:8],[7:0]}, 0 outside the active area
//   mode       current pattern (0 white, 1 bars, 2 ramp, 3 checker, 4 moving bar)
//   frame_tick one-cycle pulse following the last pixel of the frame
module h14tx_pattern_gen #(
  parameter int BitWidth       = 12,
  parameter int BitHeight      = 11,
  parameter int HActive        = 1280,
  parameter int VActive        = 720,
  parameter int HTotal         = 1650,
  parameter int VTotal         = 750,
  parameter int DebounceCycles = 1000000,
  parameter int CheckLog2      = 5,
  parameter int BarPx          = 32,
  parameter int BarStep        = 4,
  parameter int InitMode       = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 switch,
  input  logic [BitWidth-1:0]  x,
  input  logic [BitHeight-1:0] y,
  output logic [23:0]          video,
  output logic [2:0]           mode,
  output logic                 frame_tick
);

  localparam int CntW = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

  localparam logic [BitWidth-1:0] Edge1 = BitWidth'(1 * HActive / 8);
  localparam logic [BitWidth-1:0] Edge2 = BitWidth'(2 * HActive / 8);
  localparam logic [BitWidth-1:0] Edge3 = BitWidth'(3 * HActive / 8);
  localparam logic [BitWidth-1:0] Edge4 = BitWidth'(4 * HActive / 8);
  localparam logic [BitWidth-1:0] Edge5 = BitWidth'(5 * HActive / 8);
  localparam logic [BitWidth-1:0] Edge6 = BitWidth'(6 * HActive / 8);
  localparam logic [BitWidth-1:0] Edge7 = BitWidth'(7 * HActive / 8);

  logic            sync_p0, sync_p1;
  logic            db_level;
  logic [CntW-1:0] db_cnt;
  logic            db_differ, db_done, press;
  logic            pending;
  logic [BitWidth-1:0] pos;
  logic [BitWidth:0]   pos_sum;
  logic [BitWidth-1:0] pos_next;
  logic [2:0]      mode_inc;
  logic            frame_end;

  // Pixel colour for one coordinate; x/y are assumed to be inside the active area.
  function automatic logic [23:0] pattern_rgb(input logic [2:0]           m,
                                              input logic [BitWidth-1:0]  px,
                                              input logic [BitHeight-1:0] py,
                                              input logic [BitWidth-1:0]  bar_pos);
    logic [BitWidth:0] px_w, lo_w, hi_w;
    logic [23:0] rgb;
    px_w = {1'b0, px};
    lo_w = {1'b0, bar_pos};
    hi_w = lo_w + (BitWidth+1)'(BarPx);
    rgb  = 24'h000000;
    case (m)
      3'd0: rgb = 24'hFFFFFF;
      3'd1: begin
        if      (px < Edge1) rgb = 24'hFFFFFF;
        else if (px < Edge2) rgb = 24'hFFFF00;
        else if (px < Edge3) rgb = 24'h00FFFF;
        else if (px < Edge4) rgb = 24'h00FF00;
        else if (px < Edge5) rgb = 24'hFF00FF;
        else if (px < Edge6) rgb = 24'hFF0000;
        else if (px < Edge7) rgb = 24'h0000FF;
        else                 rgb = 24'h000000;
      end
      3'd2: rgb = {px[7:0], px[7:0], px[7:0]};
      3'd3: rgb = (px[CheckLog2] ^ py[CheckLog2]) ? 24'hFFFFFF : 24'h000000;
      // Right-edge clipping falls out of the active-area blanking in the caller.
      3'd4: rgb = (px_w >= lo_w && px_w < hi_w) ? 24'hFFFFFF : 24'h000080;
      default: rgb = 24'h000000;
    endcase
    return rgb;
  endfunction

  // Stage p0/p1: two-flop synchroniser for the raw switch
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= switch;
      sync_p1 <= sync_p0;
    end
  end

  assign db_differ = (sync_p1 != db_level);
  assign db_done   = db_differ && (db_cnt == CntMax);
  assign press     = db_done && !db_level;

  // Debounce: count consecutive samples that disagree with the accepted level
  always_ff @(posedge clk) begin
    if (rst) begin
      db_level <= 1'b0;
      db_cnt   <= '0;
    end else if (!db_differ) begin
      db_cnt   <= '0;
    end else if (db_done) begin
      db_level <= ~db_level;
      db_cnt   <= '0;
    end else begin
      db_cnt   <= db_cnt + 1'b1;
    end
  end

  assign frame_end = (x == BitWidth'(HTotal - 1)) && (y == BitHeight'(VTotal - 1));

  always_comb begin
    pos_sum  = {1'b0, pos} + (BitWidth+1)'(BarStep);
    pos_next = (pos_sum >= (BitWidth+1)'(HActive)) ? '0 : pos_sum[BitWidth-1:0];
    mode_inc = (mode == 3'd4) ? 3'd0 : mode + 3'd1;
  end

  // Frame-boundary control: mode stepping, bar animation, tick
  always_ff @(posedge clk) begin
    if (rst) begin
      mode       <= 3'(InitMode);
      pending    <= 1'b0;
      pos        <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end;
      if (frame_end) begin
        if (pending) mode <= mode_inc;
        pos     <= pos_next;
        // A press landing on the boundary cycle is held for the next frame.
        pending <= press;
      end else if (press) begin
        pending <= 1'b1;
      end
    end
  end

  // Stage p1: registered pixel output
  always_ff @(posedge clk) begin
    if (rst) begin
      video <= 24'h000000;
    end else if (({1'b0, x} >= (BitWidth+1)'(HActive)) ||
                 ({1'b0, y} >= (BitHeight+1)'(VActive))) begin
      video <= 24'h000000;
    end else begin
      video <= pattern_rgb(mode, x, y, pos);
    end
  end

endmodule

// File: tb/tb_h14tx_pattern_gen.sv
module tb_h14tx_pattern_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        switch;
  logic [11:0] x;
  logic [10:0] y;
  logic [23:0] video;
  logic [2:0]  mode;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  // Bench-side model of the control state
  int cur_m  = 0;
  bit pend_m = 0;
  int pos_m  = 0;

  h14tx_pattern_gen #(
    .BitWidth(12), .BitHeight(11), .HActive(1280), .VActive(720),
    .HTotal(1650), .VTotal(750), .DebounceCycles(16), .CheckLog2(5),
    .BarPx(32), .BarStep(4), .InitMode(0)
  ) dut (
    .clk(clk), .rst(rst), .switch(switch), .x(x), .y(y),
    .video(video), .mode(mode), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  m;
    int          px;
    int          py;
    logic [23:0] exp;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %06h expected %06h", nm, act, exp);
    end
  endtask

  task automatic pixel(input string nm, input int px, input int py, input logic [23:0] exp);
    x = px[11:0];
    y = py[10:0];
    tick();
    chk(nm, video, exp);
  endtask

  // Debounced press: held long enough to be accepted, then released fully.
  task automatic press();
    x = 12'd10; y = 11'd10;
    switch = 1'b1;
    repeat (20) tick();
    switch = 1'b0;
    repeat (20) tick();
    pend_m = 1'b1;
  endtask

  task automatic boundary();
    x = 12'd1649; y = 11'd749;
    tick();
    if (pend_m) cur_m = (cur_m == 4) ? 0 : cur_m + 1;
    pend_m = 1'b0;
    pos_m  = (pos_m + 4 >= 1280) ? 0 : pos_m + 4;
    chk("frame_tick_pulse", {23'd0, frame_tick}, 24'd1);
    chk("mode_at_boundary", {21'd0, mode}, cur_m[23:0]);
    x = 12'd10; y = 11'd10;
    tick();
    chk("frame_tick_clear", {23'd0, frame_tick}, 24'd0);
  endtask

  task automatic set_mode(input int target);
    while (cur_m != target) begin
      press();
      boundary();
    end
  endtask

  initial begin
    vecs[0]  = '{"m0_origin",    3'd0,    0,   0, 24'hFFFFFF};
    vecs[1]  = '{"m0_mid",       3'd0,  640, 360, 24'hFFFFFF};
    vecs[2]  = '{"m0_last",      3'd0, 1279, 719, 24'hFFFFFF};
    vecs[3]  = '{"m0_hblank",    3'd0, 1280,   0, 24'h000000};
    vecs[4]  = '{"m0_vblank",    3'd0,    0, 720, 24'h000000};
    vecs[5]  = '{"m1_x0",        3'd1,    0,  10, 24'hFFFFFF};
    vecs[6]  = '{"m1_x159",      3'd1,  159,  10, 24'hFFFFFF};
    vecs[7]  = '{"m1_x160",      3'd1,  160,  10, 24'hFFFF00};
    vecs[8]  = '{"m1_x320",      3'd1,  320,  10, 24'h00FFFF};
    vecs[9]  = '{"m1_x480",      3'd1,  480,  10, 24'h00FF00};
    vecs[10] = '{"m1_x640",      3'd1,  640,  10, 24'hFF00FF};
    vecs[11] = '{"m1_x800",      3'd1,  800,  10, 24'hFF0000};
    vecs[12] = '{"m1_x960",      3'd1,  960,  10, 24'h0000FF};
    vecs[13] = '{"m1_x1279",     3'd1, 1279,  10, 24'h000000};
    vecs[14] = '{"m2_x300",      3'd2,  300,  10, 24'h2C2C2C};
    vecs[15] = '{"m2_x255",      3'd2,  255,   0, 24'hFFFFFF};
    vecs[16] = '{"m2_hblank",    3'd2, 1300,   0, 24'h000000};
    vecs[17] = '{"m3_0_0",       3'd3,    0,   0, 24'h000000};
    vecs[18] = '{"m3_32_0",      3'd3,   32,   0, 24'hFFFFFF};
    vecs[19] = '{"m3_32_32",     3'd3,   32,  32, 24'h000000};
    vecs[20] = '{"m3_0_32",      3'd3,    0,  32, 24'hFFFFFF};
    vecs[21] = '{"m3_31_31",     3'd3,   31,  31, 24'h000000};

    rst = 1'b1; switch = 1'b0; x = 12'd100; y = 11'd100;
    tick();
    chk("reset_video", video, 24'h000000);
    chk("reset_mode", {21'd0, mode}, 24'd0);
    chk("reset_tick", {23'd0, frame_tick}, 24'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < NV; i++) begin
      set_mode(int'(vecs[i].m));
      pixel(vecs[i].name, vecs[i].px, vecs[i].py, vecs[i].exp);
    end

    // Debounced press mid-frame: mode must hold until the boundary
    x = 12'd100; y = 11'd100;
    switch = 1'b1;
    repeat (18) tick();
    switch = 1'b0;
    pend_m = 1'b1;
    chk("press_no_early_change", {21'd0, mode}, 24'd3);
    repeat (20) tick();
    chk("press_still_pending", {21'd0, mode}, 24'd3);
    boundary();
    chk("press_applied", {21'd0, mode}, 24'd4);

    // Glitch shorter than the debounce window is ignored
    switch = 1'b1;
    repeat (10) tick();
    switch = 1'b0;
    repeat (20) tick();
    boundary();
    chk("glitch_ignored", {21'd0, mode}, 24'd4);

    // Moving bar: animate up to pos=1264
    while (pos_m != 1264) boundary();
    pixel("bar1264_x1264", 1264, 100, 24'hFFFFFF);
    pixel("bar1264_x1279", 1279, 100, 24'hFFFFFF);
    pixel("bar1264_x1263", 1263, 100, 24'h000080);
    pixel("bar1264_x1280", 1280, 100, 24'h000000);
    while (pos_m != 1276) boundary();
    pixel("bar1276_x1276", 1276, 5, 24'hFFFFFF);
    pixel("bar1276_x1275", 1275, 5, 24'h000080);
    boundary();
    pixel("bar_wrap_x0", 0, 5, 24'hFFFFFF);
    pixel("bar_wrap_x31", 31, 5, 24'hFFFFFF);
    pixel("bar_wrap_x32", 32, 5, 24'h000080);

    // Three presses within one frame from mode 4 step once, to 0
    press(); press(); press();
    chk("multi_press_pending", {21'd0, mode}, 24'd4);
    boundary();
    chk("multi_press_once", {21'd0, mode}, 24'd0);
    boundary();
    chk("multi_press_no_extra", {21'd0, mode}, 24'd0);

    // Mid-line reset
    set_mode(2);
    pixel("pre_reset_grey", 50, 5, 24'h323232);
    rst = 1'b1;
    tick();
    chk("midline_reset_video", video, 24'h000000);
    chk("midline_reset_mode", {21'd0, mode}, 24'd0);
    chk("midline_reset_tick", {23'd0, frame_tick}, 24'd0);
    rst = 1'b0;
    cur_m = 0; pend_m = 1'b0; pos_m = 0;
    tick();
    set_mode(4);
    pixel("post_reset_bar_x16", 16, 5, 24'hFFFFFF);
    pixel("post_reset_bar_x15", 15, 5, 24'h000080);
    pixel("post_reset_bar_x47", 47, 5, 24'hFFFFFF);
    pixel("post_reset_bar_x48", 48, 5, 24'h000080);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
